rr_grant_arbiter8: RTL and testbench

Cycle-based arbiter that shares one resource among eight requesters, using an 8-to-3 LSB-first priority encoder as its selection datapath. It supports two priority modes:

- **Round-robin:** a rotating pointer masks the request vector before encoding.
- **Fixed:** bit 0 is always the highest priority.

The grant is registered, one-hot and indexed, and is held while the owner keeps requesting, up to a configurable hold limit. It sits between the requester ports and the shared resource's select mux.

---
 rtl/arb_pkg.sv | 12 +
 rtl/lsb_prio_enc8.sv | 16 +
 rtl/rr_grant_arbiter8.sv | 86 ++++++++
 tb/tb_rr_grant_arbiter8.sv | 109 ++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the eight-way round-robin grant arbiter.
package arb_pkg;
  localparam int NREQ = 8;
  localparam int IDW  = 3;

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
    onehot = '0;
    onehot[id] = 1'b1;
  endfunction
endpackage

// File: rtl/lsb_prio_enc8.sv
// 8->3 lowest-set-bit priority encoder with an any-valid flag.
module lsb_prio_enc8
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] i_vec,
  output logic [IDW-1:0]  o_id,
  output logic            o_vld
);
  always_comb begin
    o_id  = '0;
    o_vld = |i_vec;
    // Scan high to low so the lowest set bit is the last one written.
    for (int i = NREQ-1; i >= 0; i--)
      if (i_vec[i]) o_id = IDW'(i);
  end
endmodule

// File: rtl/rr_grant_arbiter8.sv
// Eight-requester arbiter: round-robin or fixed priority, registered one-hot grant,
// and a hold limit that forces a hand-off when others are waiting.
module rr_grant_arbiter8
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_rr,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_vld,
  output logic            preempt
);
  localparam logic [7:0] HOLD_LIM = (HOLD_MAX == 0) ? 8'd0 : 8'(HOLD_MAX - 1);

  state_t          r_state, w_state_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [7:0]      r_hcnt;
  logic [NREQ-1:0] r_gnt;
  logic [IDW-1:0]  r_gnt_id;
  logic            r_gnt_vld, r_preempt;

  logic [IDW-1:0]  w_ptr_eff, w_m_id, w_u_id, w_winner;
  logic [NREQ-1:0] w_masked;
  logic            w_m_vld, w_u_vld;
  logic            w_case_a, w_case_b, w_case_c, w_arb;

  assign w_ptr_eff = cfg_rr ? r_ptr : '0;
  assign w_masked  = req & ({NREQ{1'b1}} << w_ptr_eff);

  lsb_prio_enc8 u_enc_masked (.i_vec(w_masked), .o_id(w_m_id), .o_vld(w_m_vld));
  lsb_prio_enc8 u_enc_unmask (.i_vec(req),      .o_id(w_u_id), .o_vld(w_u_vld));

  // Unmasked fallback provides the wrap-around once everything above ptr is quiet.
  assign w_winner = w_m_vld ? w_m_id : w_u_id;

  assign w_case_a = (r_state == IDLE) && w_u_vld;
  assign w_case_b = (r_state == BUSY) && !req[r_gnt_id];
  assign w_case_c = (r_state == BUSY) && (HOLD_MAX != 0) && (r_hcnt == HOLD_LIM)
                    && |(req & ~r_gnt);
  assign w_arb    = w_case_a || w_case_b || w_case_c;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    if (w_arb) w_state_nxt = w_u_vld ? BUSY : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_hcnt    <= '0;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_gnt_vld <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      if (w_arb && w_u_vld) begin
        r_gnt     <= onehot(w_winner);
        r_gnt_id  <= w_winner;
        r_gnt_vld <= 1'b1;
        r_hcnt    <= '0;
        r_ptr     <= w_winner + 3'd1;
        // An owner that dropped its request is a normal hand-off, not a preemption.
        r_preempt <= w_case_c && !w_case_b;
      end else if (w_arb) begin
        r_gnt     <= '0;
        r_gnt_vld <= 1'b0;
      end else if (r_state == BUSY && r_hcnt != 8'hFF) begin
        r_hcnt <= r_hcnt + 8'd1;
      end
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign gnt_vld = r_gnt_vld;
  assign preempt = r_preempt;
endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// Directed bench for rr_grant_arbiter8 with HOLD_MAX=4 and hand-computed expectations.
module tb_rr_grant_arbiter8;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_rr;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_vld, preempt;

  int n_chk = 0;
  int n_err = 0;

  rr_grant_arbiter8 #(.HOLD_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_rr(cfg_rr), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .preempt(preempt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic [7:0] g, input logic [2:0] id,
                         input logic v, input logic p);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".id"},  32'(gnt_id), 32'(id));
    chk({tag, ".vld"}, 32'(gnt_vld), 32'(v));
    chk({tag, ".pre"}, 32'(preempt), 32'(p));
  endtask

  logic [7:0] hold_g [9] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h01};
  logic       hold_p [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0; cfg_rr = 1'b1; req = 8'h00;
    #12;
    chk_gnt("rst_async", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk_gnt("rst_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    req = 8'h10; tick();
    chk_gnt("single", 8'h10, 3'd4, 1'b1, 1'b0);

    // Fresh reset so the pointer starts at 0 for the round-robin sweep.
    @(negedge clk); rst_n = 1'b0; #2; rst_n = 1'b1;
    req = 8'hFF; tick();
    chk_gnt("rr0", 8'h01, 3'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      req = 8'hFF & ~(8'h01 << ((k - 1) % 8));
      tick();
      chk_gnt($sformatf("rr%0d", k), 8'h01 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
    end

    // Fixed priority: owner 0 drops, lowest remaining bit wins.
    cfg_rr = 1'b0;
    req = 8'h0C; tick();
    chk_gnt("fix2", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h08; tick();
    chk_gnt("fix3", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h0C; tick();
    chk_gnt("fix3hold", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h04; tick();
    chk_gnt("fix2b", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h00; tick();
    chk_gnt("idle", 8'h00, 3'd2, 1'b0, 1'b0);

    // Hold limit of 4 with two steady requesters.
    cfg_rr = 1'b1;
    req = 8'h03;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk_gnt($sformatf("hold%0d", k), hold_g[k], hold_g[k][1] ? 3'd1 : 3'd0, 1'b1, hold_p[k]);
    end

    // Lone owner past the limit keeps the grant without preemption.
    req = 8'h20;
    for (int k = 0; k < 11; k++) begin
      tick();
      chk_gnt($sformatf("lone%0d", k), 8'h20, 3'd5, 1'b1, 1'b0);
    end

    req = 8'h80; tick();
    chk_gnt("own7", 8'h80, 3'd7, 1'b1, 1'b0);
    @(negedge clk); rst_n = 1'b0; #1;
    chk_gnt("rst_mid", 8'h00, 3'd0, 1'b0, 1'b0);
    #1; rst_n = 1'b1;
    req = 8'h81; tick();
    chk_gnt("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h82; tick();
    chk_gnt("post_rst1", 8'h02, 3'd1, 1'b1, 1'b0);
    req = 8'h00; tick();
    chk_gnt("idle_hold", 8'h00, 3'd1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
